mem_arbiter: RTL and testbench

- Shares the single backing-memory request/data/response channel between the instruction-cache refill engine (client IC, read-only) and the data-cache refill/writeback engine (client DC, read/write).
- Sits inside Memory151, between the two cache controllers and the top-level mem_req/mem_resp ports.
- Locks the grant across a write's data beats.
- Routes responses back to the issuing client using the tag MSB.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_rr_arb2.sv | 21 ++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the memory-channel arbiter.
// Client ids double as the memory-side tag MSB used for response routing.
package mem_arbiter_pkg;

    localparam int unsigned MEM_ADDR_BITS = 28;
    localparam int unsigned MEM_DATA_BITS = 128;
    localparam int unsigned MEM_TAG_BITS  = 5;

    typedef enum logic [1:0] {
        MEM_ARB_IDLE,
        MEM_ARB_REQ,
        MEM_ARB_WDATA
    } arb_state_t;

    typedef enum logic {
        MEM_ARB_ID_DC = 1'b0,
        MEM_ARB_ID_IC = 1'b1
    } client_id_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker between the DC and IC clients (combinational).
// On a tie the client that was not granted last wins.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       dc_valid,
    input  logic       ic_valid,
    input  client_id_t last,
    output client_id_t grant
);

    always_comb begin
        grant = MEM_ARB_ID_DC;
        if (dc_valid && ic_valid) begin
            grant = (last == MEM_ARB_ID_DC) ? MEM_ARB_ID_IC : MEM_ARB_ID_DC;
        end else if (ic_valid) begin
            grant = MEM_ARB_ID_IC;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory request/data/response channel between IC and DC.
// Define MEM_ARB_FIXED_PRIO_EN to make DC always win ties (no round-robin state).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = MEM_ADDR_BITS,
    parameter int unsigned DATA_BITS  = MEM_DATA_BITS,
    parameter int unsigned TAG_BITS   = MEM_TAG_BITS,
    parameter int unsigned DATA_BEATS = 4
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   dc_req_valid,
    output logic                   dc_req_ready,
    input  logic                   dc_req_rw,
    input  logic [ADDR_BITS-1:0]   dc_req_addr,
    input  logic [TAG_BITS-2:0]    dc_req_tag,
    input  logic                   dc_data_valid,
    output logic                   dc_data_ready,
    input  logic [DATA_BITS-1:0]   dc_data_bits,
    input  logic [DATA_BITS/8-1:0] dc_data_mask,
    output logic                   dc_resp_valid,
    output logic [TAG_BITS-2:0]    dc_resp_tag,
    output logic [DATA_BITS-1:0]   dc_resp_data,

    input  logic                   ic_req_valid,
    output logic                   ic_req_ready,
    input  logic [ADDR_BITS-1:0]   ic_req_addr,
    input  logic [TAG_BITS-2:0]    ic_req_tag,
    output logic                   ic_resp_valid,
    output logic [TAG_BITS-2:0]    ic_resp_tag,
    output logic [DATA_BITS-1:0]   ic_resp_data,

    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_rw,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic [TAG_BITS-1:0]    mem_req_tag,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [TAG_BITS-1:0]    mem_resp_tag,
    input  logic [DATA_BITS-1:0]   mem_resp_data
);

    localparam int unsigned CNT_W = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DATA_BEATS - 1);

    arb_state_t       state_q, state_d;
    client_id_t       grant_q, grant_d;
    client_id_t       arb_last, arb_grant;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic             sel_valid;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Pretending IC was last served makes the picker favour DC on every tie.
    assign arb_last = MEM_ARB_ID_IC;
`else
    client_id_t rr_last_q, rr_last_d;
    assign arb_last = rr_last_q;
`endif

    rr_arb2 u_rr_arb2 (
        .dc_valid (dc_req_valid),
        .ic_valid (ic_req_valid),
        .last     (arb_last),
        .grant    (arb_grant)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= MEM_ARB_IDLE;
            grant_q   <= MEM_ARB_ID_DC;
            beat_q    <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_last_q <= MEM_ARB_ID_IC;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            beat_q    <= beat_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

    always_comb begin
        state_d            = state_q;
        grant_d            = grant_q;
        beat_d             = beat_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        rr_last_d          = rr_last_q;
`endif
        sel_valid          = 1'b0;
        dc_req_ready       = 1'b0;
        ic_req_ready       = 1'b0;
        dc_data_ready      = 1'b0;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_addr       = '0;
        mem_req_tag        = '0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;

        unique case (state_q)
            MEM_ARB_IDLE: begin
                if (dc_req_valid || ic_req_valid) begin
                    grant_d = arb_grant;
                    state_d = MEM_ARB_REQ;
                end
            end
            MEM_ARB_REQ: begin
                if (grant_q == MEM_ARB_ID_IC) begin
                    sel_valid    = ic_req_valid;
                    mem_req_rw   = 1'b0;
                    mem_req_addr = ic_req_addr;
                    mem_req_tag  = {grant_q, ic_req_tag};
                    ic_req_ready = mem_req_ready;
                end else begin
                    sel_valid    = dc_req_valid;
                    mem_req_rw   = dc_req_rw;
                    mem_req_addr = dc_req_addr;
                    mem_req_tag  = {grant_q, dc_req_tag};
                    dc_req_ready = mem_req_ready;
                end
                mem_req_valid = sel_valid;
                if (sel_valid && mem_req_ready) begin
`ifndef MEM_ARB_FIXED_PRIO_EN
                    rr_last_d = grant_q;
`endif
                    if (mem_req_rw) begin
                        state_d = MEM_ARB_WDATA;
                        beat_d  = '0;
                    end else begin
                        state_d = MEM_ARB_IDLE;
                    end
                end
            end
            MEM_ARB_WDATA: begin
                mem_req_data_valid = dc_data_valid;
                mem_req_data_bits  = dc_data_bits;
                mem_req_data_mask  = dc_data_mask;
                dc_data_ready      = mem_req_data_ready;
                if (dc_data_valid && mem_req_data_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = MEM_ARB_IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = MEM_ARB_IDLE;
        endcase
    end

    // Response routing is stateless so in-flight responses survive a reset.
    assign dc_resp_valid = mem_resp_valid & ~mem_resp_tag[TAG_BITS-1];
    assign ic_resp_valid = mem_resp_valid &  mem_resp_tag[TAG_BITS-1];
    assign dc_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
    assign ic_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
    assign dc_resp_data  = mem_resp_data;
    assign ic_resp_data  = mem_resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (round-robin default build;
// tie expectations switch when MEM_ARB_FIXED_PRIO_EN is defined).
module tb_mem_arbiter;

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 128;
    localparam int unsigned TW = 5;
    localparam int unsigned NB = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            dc_req_valid, dc_req_ready, dc_req_rw;
    logic [AW-1:0]   dc_req_addr;
    logic [TW-2:0]   dc_req_tag;
    logic            dc_data_valid, dc_data_ready;
    logic [DW-1:0]   dc_data_bits;
    logic [DW/8-1:0] dc_data_mask;
    logic            dc_resp_valid;
    logic [TW-2:0]   dc_resp_tag;
    logic [DW-1:0]   dc_resp_data;
    logic            ic_req_valid, ic_req_ready;
    logic [AW-1:0]   ic_req_addr;
    logic [TW-2:0]   ic_req_tag;
    logic            ic_resp_valid;
    logic [TW-2:0]   ic_resp_tag;
    logic [DW-1:0]   ic_resp_data;
    logic            mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AW-1:0]   mem_req_addr;
    logic [TW-1:0]   mem_req_tag;
    logic            mem_req_data_valid, mem_req_data_ready;
    logic [DW-1:0]   mem_req_data_bits;
    logic [DW/8-1:0] mem_req_data_mask;
    logic            mem_resp_valid;
    logic [TW-1:0]   mem_resp_tag;
    logic [DW-1:0]   mem_resp_data;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    int unsigned fwd;
    logic [5:0]  pat;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_BITS  (AW),
        .DATA_BITS  (DW),
        .TAG_BITS   (TW),
        .DATA_BEATS (NB)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .dc_req_valid       (dc_req_valid),
        .dc_req_ready       (dc_req_ready),
        .dc_req_rw          (dc_req_rw),
        .dc_req_addr        (dc_req_addr),
        .dc_req_tag         (dc_req_tag),
        .dc_data_valid      (dc_data_valid),
        .dc_data_ready      (dc_data_ready),
        .dc_data_bits       (dc_data_bits),
        .dc_data_mask       (dc_data_mask),
        .dc_resp_valid      (dc_resp_valid),
        .dc_resp_tag        (dc_resp_tag),
        .dc_resp_data       (dc_resp_data),
        .ic_req_valid       (ic_req_valid),
        .ic_req_ready       (ic_req_ready),
        .ic_req_addr        (ic_req_addr),
        .ic_req_tag         (ic_req_tag),
        .ic_resp_valid      (ic_resp_valid),
        .ic_resp_tag        (ic_resp_tag),
        .ic_resp_data       (ic_resp_data),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_rw         (mem_req_rw),
        .mem_req_addr       (mem_req_addr),
        .mem_req_tag        (mem_req_tag),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_tag       (mem_resp_tag),
        .mem_resp_data      (mem_resp_data)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0; dc_req_tag = '0;
        dc_data_valid = 0; dc_data_bits = '0; dc_data_mask = '0;
        ic_req_valid = 0; ic_req_addr = '0; ic_req_tag = '0;
        mem_req_ready = 0; mem_req_data_ready = 0;
        mem_resp_valid = 0; mem_resp_tag = '0; mem_resp_data = '0;
    endtask

    initial begin
        clear_inputs();
        reset = 0;
        tick(); tick();
        #1;
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_dc_req_ready", dc_req_ready, 0);
        check("rst_ic_req_ready", ic_req_ready, 0);
        check("rst_dc_data_ready", dc_data_ready, 0);
        check("rst_mem_data_valid", mem_req_data_valid, 0);
        check("rst_mem_req_addr", mem_req_addr, 0);
        reset = 1;

        // IC read: one cycle of latency, ready follows mem_req_ready.
        tick();
        ic_req_valid = 1; ic_req_addr = 28'h100; ic_req_tag = 4'd3;
        #1 check("ic_rd_latency", mem_req_valid, 0);
        tick();
        #1;
        check("ic_rd_valid", mem_req_valid, 1);
        check("ic_rd_tag", mem_req_tag, 5'b10011);
        check("ic_rd_addr", mem_req_addr, 28'h100);
        check("ic_rd_rw", mem_req_rw, 0);
        check("ic_rd_ready_lo", ic_req_ready, 0);
        mem_req_ready = 1;
        #1;
        check("ic_rd_ready_hi", ic_req_ready, 1);
        check("ic_rd_dc_ready", dc_req_ready, 0);
        tick();
        ic_req_valid = 0;
        #1 check("ic_rd_done", mem_req_valid, 0);

        // Tie: DC first; a repeated tie goes to IC unless fixed priority.
        tick();
        dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 28'h200; dc_req_tag = 4'd1;
        ic_req_valid = 1; ic_req_addr = 28'h300; ic_req_tag = 4'd2;
        tick();
        #1;
        check("tie1_tag", mem_req_tag, 5'h01);
        check("tie1_dc_ready", dc_req_ready, 1);
        check("tie1_ic_ready", ic_req_ready, 0);
        tick();
        dc_req_addr = 28'h210; dc_req_tag = 4'd5;
        #1 check("tie_gap", mem_req_valid, 0);
        tick();
        #1;
`ifdef MEM_ARB_FIXED_PRIO_EN
        check("tie2_tag", mem_req_tag, 5'h05);
        check("tie2_addr", mem_req_addr, 28'h210);
`else
        check("tie2_tag", mem_req_tag, 5'h12);
        check("tie2_addr", mem_req_addr, 28'h300);
`endif
        tick();
        dc_req_valid = 0; ic_req_valid = 0;

        // DC write with IC waiting; data ready pattern 1,0,1,1,0,1.
        tick();
        dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h40; dc_req_tag = 4'd6;
        ic_req_valid = 1;
        tick();
        #1;
        check("wr_tag", mem_req_tag, 5'h06);
        check("wr_rw", mem_req_rw, 1);
        check("wr_addr", mem_req_addr, 28'h40);
        check("wr_early_data_ready", dc_data_ready, 0);
        tick();
        dc_req_valid = 0; dc_data_valid = 1; dc_data_mask = 16'h0F0F;
        pat = 6'b101101;
        fwd = 0;
        for (int i = 0; i < 6; i++) begin
            mem_req_data_ready = pat[i];
            dc_data_bits = 128'hA0 + 128'(i);
            #1;
            check("wd_data_ready", dc_data_ready, pat[i]);
            check("wd_data_valid", mem_req_data_valid, 1);
            check("wd_bits", mem_req_data_bits, 128'hA0 + 128'(i));
            check("wd_no_req", mem_req_valid, 0);
            check("wd_ic_blocked", ic_req_ready, 0);
            if (mem_req_data_valid && mem_req_data_ready) fwd++;
            tick();
        end
        check("wd_beats", fwd, 4);
        #1;
        check("wd_mask_idle", mem_req_data_mask, 0);
        check("wd_exit_ready", dc_data_ready, 0);
        check("wd_exit_valid", mem_req_data_valid, 0);
        dc_data_valid = 0; mem_req_data_ready = 0;
        tick();
        #1;
        check("post_wr_ic_tag", mem_req_tag, 5'h12);
        check("post_wr_ic_ready", ic_req_ready, 1);
        tick();
        ic_req_valid = 0;

        // Response routing by tag MSB.
        mem_resp_valid = 1; mem_resp_tag = 5'b00111; mem_resp_data = 128'hDEAD_BEEF;
        #1;
        check("resp_dc_valid", dc_resp_valid, 1);
        check("resp_dc_other", ic_resp_valid, 0);
        check("resp_dc_tag", dc_resp_tag, 4'd7);
        check("resp_dc_data", dc_resp_data, 128'hDEAD_BEEF);
        mem_resp_tag = 5'b10111;
        #1;
        check("resp_ic_valid", ic_resp_valid, 1);
        check("resp_ic_other", dc_resp_valid, 0);
        check("resp_ic_tag", ic_resp_tag, 4'd7);
        mem_resp_valid = 0;
        #1 check("resp_none", dc_resp_valid | ic_resp_valid, 0);

        // Reset in WDATA after two beats.
        tick();
        dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h80; dc_req_tag = 4'd2;
        tick();
        #1 check("rw_req", mem_req_valid, 1);
        tick();
        dc_req_valid = 0; dc_data_valid = 1; mem_req_data_ready = 1;
        #1 check("rw_wdata", dc_data_ready, 1);
        tick(); tick();
        reset = 0;
        mem_resp_valid = 1; mem_resp_tag = 5'b10001;
        #1;
        check("mid_rst_data_valid", mem_req_data_valid, 0);
        check("mid_rst_data_ready", dc_data_ready, 0);
        check("mid_rst_req_valid", mem_req_valid, 0);
        check("mid_rst_resp_route", ic_resp_valid, 1);
        check("mid_rst_resp_tag", ic_resp_tag, 4'd1);
        tick();
        reset = 1;
        dc_data_valid = 0; mem_req_data_ready = 0; mem_resp_valid = 0;
        tick();
        dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 28'h90; dc_req_tag = 4'd4;
        tick();
        #1;
        check("post_rst_rd_tag", mem_req_tag, 5'h04);
        check("post_rst_rd_addr", mem_req_addr, 28'h90);
        check("post_rst_rd_rw", mem_req_rw, 0);
        tick();
        dc_req_rw = 1; dc_req_addr = 28'hC0; dc_req_tag = 4'd8;
        tick();
        #1 check("post_rst_wr_rw", mem_req_rw, 1);
        tick();
        dc_req_valid = 0; dc_data_valid = 1; mem_req_data_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1 check("post_rst_beat_ready", dc_data_ready, 1);
            tick();
        end
        #1 check("post_rst_wr_exit", dc_data_ready, 0);
        clear_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
